// File: rtl/quad_step_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : quad_step_decoder_if
// Brief    : Signal bundle between a quadrature source and quad_step_decoder.
// Revision : 1.0
// ============================================================================
interface quad_step_decoder_if;
  logic quad_a;
  logic quad_b;
  logic err_clr;
  logic step;
  logic up_down;
  logic err;
  logic primed;

  modport master (
    output quad_a, quad_b, err_clr,
    input  step, up_down, err, primed
  );

  modport slave (
    input  quad_a, quad_b, err_clr,
    output step, up_down, err, primed
  );
endinterface
`default_nettype wire

// File: rtl/quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quad_step_decoder
// Brief    : Synchronises, filters and Gray-decodes two quadrature channels
//            into a one-cycle step pulse plus direction, with sticky err.
//            Define QUAD_X1_MODE_EN for one step per full quadrature cycle.
// Revision : 1.0
// ============================================================================
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic               clk,
  input  logic               rst,
  quad_step_decoder_if.slave bus
);

`ifdef QUAD_X1_MODE_EN
  localparam bit c_X1 = 1'b1;
`else
  localparam bit c_X1 = 1'b0;
`endif

  localparam logic [3:0] c_FILT_LAST = 4'(FILT_LEN - 1);

  logic w_raw     [2];
  logic w_filt    [2];
  logic w_settled [2];

  assign w_raw[0] = bus.quad_a;
  assign w_raw[1] = bus.quad_b;

  for (genvar g = 0; g < 2; g++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q;
    logic                   filt_d;
    logic [3:0]             cnt_q;
    logic [3:0]             cnt_d;
    logic                   w_sync;

    assign w_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
      filt_d = filt_q;
      cnt_d  = 4'd0;
      if (w_sync != filt_q) begin
        if (cnt_q == c_FILT_LAST) begin
          filt_d = w_sync;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
        filt_q <= 1'b0;
        cnt_q  <= 4'd0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], w_raw[g]};
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    // Settled also needs the whole synchroniser chain to agree, otherwise a
    // level still in flight after reset could be decoded as a step.
    assign w_filt[g]    = filt_q;
    assign w_settled[g] = (sync_q == {SYNC_STAGES{filt_q}}) && (cnt_q == 4'd0);
  end

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       step_q;
  logic       step_d;
  logic       up_down_q;
  logic       up_down_d;
  logic       err_q;
  logic       err_d;
  logic       primed_q;
  logic       primed_d;
  logic [3:0] prime_cnt_q;
  logic [3:0] prime_cnt_d;
  logic [3:0] w_trans;

  assign w_trans = {state_q, state_d};

  always_comb begin
    state_d     = {w_filt[0], w_filt[1]};
    step_d      = 1'b0;
    up_down_d   = up_down_q;
    err_d       = err_q;
    primed_d    = primed_q;
    prime_cnt_d = prime_cnt_q;

    if (bus.err_clr) begin
      err_d = 1'b0;
    end

    if (!primed_q) begin
      if (w_settled[0] && w_settled[1]) begin
        if (prime_cnt_q == c_FILT_LAST) begin
          primed_d = 1'b1;
        end else begin
          prime_cnt_d = prime_cnt_q + 4'd1;
        end
      end else begin
        prime_cnt_d = 4'd0;
      end
    end

    if (primed_q && (state_d != state_q)) begin
      case (w_trans)
        4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
          up_down_d = 1'b1;
          step_d    = !c_X1 || (w_trans == 4'b0010);
        end
        4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
          up_down_d = 1'b0;
          step_d    = !c_X1 || (w_trans == 4'b1000);
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= 2'b00;
      step_q      <= 1'b0;
      up_down_q   <= 1'b1;
      err_q       <= 1'b0;
      primed_q    <= 1'b0;
      prime_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      up_down_q   <= up_down_d;
      err_q       <= err_d;
      primed_q    <= primed_d;
      prime_cnt_q <= prime_cnt_d;
    end
  end

  assign bus.step    = step_q;
  assign bus.up_down = up_down_q;
  assign bus.err     = err_q;
  assign bus.primed  = primed_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_step_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quad_step_decoder
// Brief    : Scoreboard bench for quad_step_decoder with a Gray-position model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_quad_step_decoder;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 3;
  localparam int LAT         = SYNC_STAGES + FILT_LEN + 1;

  typedef struct {
    int when;
    bit dir;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  exp_t     q[$];
  bit [1:0] lvl = 2'b00;
  bit       exp_dir = 1'b1;
  bit       exp_err = 1'b0;

  quad_step_decoder_if bus();

  quad_step_decoder #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act == want) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
  endtask

  // Position around the quadrature cycle 00 -> 10 -> 11 -> 01.
  function automatic int pos(input bit [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit [1:0] at_pos(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic bit counts_step(input bit [1:0] from, input bit [1:0] to);
`ifdef QUAD_X1_MODE_EN
    return (from == 2'b00 && to == 2'b10) || (from == 2'b10 && to == 2'b00);
`else
    return 1'b1;
`endif
  endfunction

  // Drive a new level at a falling edge and record what the DUT must do.
  task automatic drive(input bit [1:0] nxt);
    int d;
    d = (pos(nxt) - pos(lvl) + 4) % 4;
    if (d == 2) begin
      exp_err = 1'b1;
    end else if (d != 0) begin
      exp_dir = (d == 1);
      if (counts_step(lvl, nxt)) q.push_back('{cyc + LAT, exp_dir});
    end
    lvl = nxt;
    bus.quad_a = nxt[1];
    bus.quad_b = nxt[0];
  endtask

  task automatic apply(input bit [1:0] nxt, input int hold);
    drive(nxt);
    repeat (hold) @(negedge clk);
    check("up_down_level", bus.up_down, exp_dir);
    check("err_level", bus.err, exp_err);
    check("no_pending_step", q.size(), 0);
  endtask

  task automatic glitch(input bit on_a, input int width);
    if (on_a) bus.quad_a = ~lvl[1];
    else      bus.quad_b = ~lvl[0];
    repeat (width) @(negedge clk);
    bus.quad_a = lvl[1];
    bus.quad_b = lvl[0];
    repeat (8) @(negedge clk);
    check("glitch_err", bus.err, exp_err);
    check("glitch_dir", bus.up_down, exp_dir);
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    exp_err = 1'b0;
    check("err_cleared", bus.err, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && bus.step === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_step", 1, 0);
        end else begin
          e = q.pop_front();
          check("step_cycle", cyc, e.when);
          check("step_dir", bus.up_down, e.dir);
        end
      end
    end
  end

  initial begin : stim
    int r;
    rst = 1'b1;
    bus.quad_a  = 1'b0;
    bus.quad_b  = 1'b0;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_step", bus.step, 0);
    check("rst_up_down", bus.up_down, 1);
    check("rst_err", bus.err, 0);
    check("rst_primed", bus.primed, 0);
    rst = 1'b0;
    repeat (FILT_LEN + SYNC_STAGES + 1) @(negedge clk);
    check("primed_after_reset", bus.primed, 1);
    check("idle_err", bus.err, 0);
    repeat (4) @(negedge clk);

    for (int i = 1; i <= 4; i++) apply(at_pos(i), 8);
    for (int i = 3; i >= 0; i--) apply(at_pos(i), 8);

    glitch(1'b1, 2);
    glitch(1'b0, 1);

    apply(2'b11, 8);
    clear_err();
    repeat (2) @(negedge clk);
    // Illegal 11->00 lands on the same edge as err_clr: set must win.
    drive(2'b00);
    repeat (LAT - 1) @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("err_set_wins", bus.err, 1);
    check("err_dir_kept", bus.up_down, exp_dir);
    repeat (3) @(negedge clk);
    clear_err();

    drive(2'b10);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_step", bus.step, 0);
    check("async_rst_up_down", bus.up_down, 1);
    check("async_rst_err", bus.err, 0);
    check("async_rst_primed", bus.primed, 0);
    q.delete();
    lvl = 2'b11;
    bus.quad_a = 1'b1;
    bus.quad_b = 1'b1;
    exp_dir = 1'b1;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("reprime_primed", bus.primed, 1);
    check("reprime_err", bus.err, 0);
    check("reprime_dir", bus.up_down, 1);

    for (int i = 3; i <= 6; i++) apply(at_pos(i), 8);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        apply(at_pos(pos(lvl) + 2), $urandom_range(7, 10));
        if ($urandom_range(0, 1) == 1) clear_err();
      end else if (r == 1) begin
        glitch($urandom_range(0, 1) == 1, $urandom_range(1, FILT_LEN - 1));
      end else if (r < 6) begin
        apply(at_pos(pos(lvl) + 1), $urandom_range(7, 10));
      end else begin
        apply(at_pos(pos(lvl) + 3), $urandom_range(7, 10));
      end
    end

    repeat (LAT + 2) @(negedge clk);
    check("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
`default_nettype wire
